spi_rx_capture: RTL

- Receive-side stage directly downstream of the team's SPI master.
- Consumes spi_sclk / spi_sdo / spi_cs, oversamples them in the clk_i domain and deserialises MSB-first words.
- Buffers completed words in a small FIFO with a valid/ready read port.
- Flags overflow and truncated frames; serves as the loopback checker for master output on the test setup.

---
 rtl/spi_rx_capture.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_rx_capture.sv
// spi_rx_capture: receive side of the SPI link, downstream of the SPI master.
// Oversamples sclk/sdo/cs in the clk_i domain, deserialises MSB-first words,
// and buffers completed words in a first-word-fall-through FIFO with a
// valid/ready read port. Sticky flags report dropped words (overflow) and
// frames that end with a partial word (frame error).
module spi_rx_capture #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            spi_sclk,
    input  logic                            spi_sdo,
    input  logic                            spi_cs,
    output logic [DATA_W-1:0]               rx_data_o,
    output logic                            rx_valid_o,
    input  logic                            rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
    output logic                            busy_o,
    output logic                            overflow_o,
    output logic                            frame_err_o,
    input  logic                            clr_err_i
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(DATA_W);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        WAIT_CS = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sdo_sync_r;
    logic                   sclk_prev_r;
    logic [FILL_W-1:0]      fill_r;

    logic sclk_s;
    logic cs_s;
    logic sdo_s;
    logic rise_s;
    logic sync_ready_s;

    // Equal-length synchronisers keep sclk, cs and sdo mutually aligned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sdo_sync_r  <= {SYNC_STAGES{1'b0}};
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs};
            sdo_sync_r  <= {sdo_sync_r[SYNC_STAGES-2:0], spi_sdo};
        end
    end

    // Previous synced sclk, for rising-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_prev_r <= sclk_s;
        end
    end

    // Counts cycles since reset until the synchronisers hold real pin samples;
    // the reset-loaded idle values must not be taken as "cs went high".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_r <= {FILL_W{1'b0}};
        end else if (fill_r != FILL_W'(SYNC_STAGES)) begin
            fill_r <= fill_r + FILL_W'(1);
        end else begin
            fill_r <= fill_r;
        end
    end

    // Synced views of the pins and the decoded sclk rise.
    always_comb begin
        sclk_s       = sclk_sync_r[SYNC_STAGES-1];
        cs_s         = cs_sync_r[SYNC_STAGES-1];
        sdo_s        = sdo_sync_r[SYNC_STAGES-1];
        rise_s       = sclk_s & ~sclk_prev_r;
        sync_ready_s = (fill_r == FILL_W'(SYNC_STAGES));
    end

    // ------------------------------------------------------------------
    // Deserialiser FSM
    // ------------------------------------------------------------------
    state_t              state_r;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [DATA_W-1:0]   shift_r;
    logic [DATA_W-1:0]   word_r;
    logic                push_r;
    logic                busy_r;

    logic [DATA_W-1:0]   shifted_s;
    logic                last_bit_s;
    logic                frame_evt_s;

    // Next shift value, last-bit decode and truncated-frame event.
    always_comb begin
        shifted_s   = {shift_r[DATA_W-2:0], sdo_s};
        last_bit_s  = (bit_cnt_r == CNT_W'(DATA_W - 1));
        frame_evt_s = 1'b0;
        if ((state_r == SHIFT) && cs_s && (bit_cnt_r != {CNT_W{1'b0}})) begin
            frame_evt_s = 1'b1;
        end else begin
            frame_evt_s = 1'b0;
        end
    end

    // Frame tracking and bit assembly; a completed word is handed to the
    // FIFO one cycle later through word_r/push_r. cs high beats a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= WAIT_CS;
            bit_cnt_r <= {CNT_W{1'b0}};
            shift_r   <= {DATA_W{1'b0}};
            word_r    <= {DATA_W{1'b0}};
            push_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            push_r <= 1'b0;
            case (state_r)
                WAIT_CS: begin
                    if (sync_ready_s && cs_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_CS;
                    end
                    busy_r <= 1'b0;
                end
                IDLE: begin
                    if (!cs_s) begin
                        state_r   <= SHIFT;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        shift_r   <= {DATA_W{1'b0}};
                        busy_r    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        state_r   <= IDLE;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        shift_r   <= {DATA_W{1'b0}};
                        busy_r    <= 1'b0;
                    end else if (rise_s) begin
                        shift_r <= shifted_s;
                        if (last_bit_s) begin
                            word_r    <= shifted_s;
                            push_r    <= 1'b1;
                            bit_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r   <= WAIT_CS;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              valid_r;

    logic              full_s;
    logic              pop_s;
    logic              wr_en_s;
    logic              ovf_evt_s;
    logic [PTR_W:0]    count_nxt_s;

    // Push/pop qualification. When full, a same-cycle pop frees the slot
    // the push lands in, so both proceed and nothing is dropped.
    always_comb begin
        full_s      = (count_r == (PTR_W+1)'(FIFO_DEPTH));
        pop_s       = rx_ready_i && valid_r;
        wr_en_s     = push_r && (!full_s || pop_s);
        ovf_evt_s   = push_r && full_s && !pop_s;
        count_nxt_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
            2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers and occupancy; pointers wrap modulo depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= word_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != {(PTR_W+1){1'b0}});
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic overflow_r;
    logic frame_err_r;

    // Sticky flags; a new event in the same cycle as clear wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err_i) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (frame_evt_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_err_i) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign rx_data_o    = mem_r[rd_ptr_r];
    assign rx_valid_o   = valid_r;
    assign fifo_count_o = count_r;
    assign busy_o       = busy_r;
    assign overflow_o   = overflow_r;
    assign frame_err_o  = frame_err_r;

endmodule
